// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_MAX_HOLD = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } pick_t;

   // Scans from the highest rotated offset down so the entry nearest ptr is written last and wins.
   function automatic pick_t rr_find(input logic [7:0] req, input int ptr, input int n);
      pick_t p;
      int    i;
      p = '0;
      for (int k = 7; k >= 0; k--) begin
         if (k < n) begin
            i = ptr + k;
            if (i >= n) i = i - n;
            if (req[3'(i)]) begin
               p.valid = 1'b1;
               p.idx   = 3'(i);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_tff_arbiter_if.sv
// Request/grant bundle between clients and the shared datapath arbiter.
interface rr_tff_arbiter_if
   import arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int PW = $clog2(N)
);
   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic [PW-1:0] gnt_id;
   logic          busy;
   logic          timeout;

   modport master (output req, input gnt, gnt_id, busy, timeout);
   modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_tff_arbiter_rr_pick.sv
// Combinational rotate-and-find-first over the request vector.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx
);
   pick_t pick;

   always_comb begin
      pick  = rr_find(8'(req), int'(ptr), N);
      valid = pick.valid;
      idx   = pick.idx[PW-1:0];
   end
endmodule

// File: rtl/rr_tff_arbiter.sv
// Round-robin owner arbiter for the shared T-FF datapath; gnt_id steers the datapath input mux.
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate from ptr on any request
//   ST_GRANT | one owner holds the datapath until release or hold limit
module rr_tff_arbiter
   import arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int PW       = $clog2(N),
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic           Clk,
   input  logic           rst,
   rr_tff_arbiter_if.slave bus
);
   state_t        state, state_nxt;
   logic [PW-1:0] ptr, ptr_nxt;
   logic [CW-1:0] hold_cnt, hold_nxt;
   logic [N-1:0]  gnt_q, gnt_nxt;
   logic [PW-1:0] id_q, id_nxt;
   logic          busy_q, busy_nxt;
   logic          to_q, to_nxt;
   logic          pick_valid;
   logic [PW-1:0] pick_idx;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         gnt_q    <= '0;
         id_q     <= '0;
         busy_q   <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         gnt_q    <= gnt_nxt;
         id_q     <= id_nxt;
         busy_q   <= busy_nxt;
         to_q     <= to_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      gnt_nxt   = gnt_q;
      id_nxt    = id_q;
      busy_nxt  = busy_q;
      to_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nxt = ST_GRANT;
               gnt_nxt   = N'(1) << pick_idx;
               id_nxt    = pick_idx;
               busy_nxt  = 1'b1;
               hold_nxt  = CW'(1);
            end
         end
         ST_GRANT: begin
            // Any release returns to IDLE, which guarantees one gnt=0 settle cycle before the next owner.
            if (!bus.req[id_q] || hold_cnt == CW'(MAX_HOLD)) begin
               state_nxt = ST_IDLE;
               gnt_nxt   = '0;
               id_nxt    = '0;
               busy_nxt  = 1'b0;
               hold_nxt  = '0;
               ptr_nxt   = (id_q == PW'(N - 1)) ? '0 : id_q + PW'(1);
               to_nxt    = bus.req[id_q];
            end else begin
               hold_nxt = hold_cnt + CW'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = id_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = to_q;

   a_onehot: assert property (@(posedge Clk) disable iff (!rst) $onehot0(gnt_q));
   a_busy:   assert property (@(posedge Clk) disable iff (!rst) busy_q == |gnt_q);
   a_id:     assert property (@(posedge Clk) disable iff (!rst)
                              busy_q ? gnt_q[id_q] : (id_q == '0));
endmodule
